// File: rtl/kpn_channel_reader.sv
// kpn_channel_reader: Kahn blocking-read endpoint that pops a channel FIFO through a 2-entry skid buffer onto a valid/ready token port
module kpn_channel_reader #(
    parameter int B  = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    input  logic [B-1:0]  fifo_dout,
    output logic          tok_valid,
    output logic [B-1:0]  tok_data,
    input  logic          tok_ready,
    output logic [CW-1:0] tok_count,
    output logic          starved
);
    logic [1:0]   occ, rem;
    logic [2:0]   occ_next;
    logic         inflight, pop;
    logic [B-1:0] head, tail;
    always_comb begin
        pop      = tok_valid & tok_ready;
        rem      = occ - {1'b0, pop};
        occ_next = {1'b0, rem} + {2'b0, inflight};
        fifo_rd  = reset_n & enable & ~fifo_empty & (occ_next < 3'd2);
    end
    assign tok_valid = occ != 2'd0;
    assign tok_data  = head;
    assign starved   = reset_n & enable & fifo_empty & ~tok_valid & ~inflight;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ       <= '0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            tok_count <= '0;
        end else begin
            inflight  <= fifo_rd;
            occ       <= occ_next[1:0];
            tok_count <= tok_count + CW'(pop);
            head      <= (inflight && rem == 2'd0) ? fifo_dout : (pop ? tail : head);
            tail      <= (inflight && rem == 2'd1) ? fifo_dout : tail;
        end
    end
endmodule

// File: tb/tb_kpn_channel_reader.sv
// tb_kpn_channel_reader: randomized and directed bench with a FIFO model and an in-order token scoreboard
module tb_kpn_channel_reader;
    localparam int B  = 16;
    localparam int CW = 4;
    logic          clk = 0, reset_n = 0, enable = 0, fifo_empty = 1, tok_ready = 0;
    logic          fifo_rd, tok_valid, starved;
    logic [B-1:0]  fifo_dout = '0, tok_data;
    logic [CW-1:0] tok_count;
    int            tests = 0, fails = 0;
    logic [B-1:0]  fq[$], eq[$];
    int            held = 0, cnt = 0, rd_total = 0, streak = 0, max_streak = 0;
    logic          rd_prev = 0, rd_s = 0, pop_s = 0;
    int            r0, c0, n;

    kpn_channel_reader #(.B(B), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .tok_valid(tok_valid), .tok_data(tok_data),
        .tok_ready(tok_ready), .tok_count(tok_count), .starved(starved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [B-1:0] w);
        fq.push_back(w);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // per-cycle checks against the held-word count and the in-order scoreboard
    always begin
        @(negedge clk);
        #1;
        if (!reset_n) begin
            check("rst_valid", tok_valid, 0);
            check("rst_count", tok_count, 0);
            check("rst_rd", fifo_rd, 0);
            check("rst_starved", starved, 0);
        end else begin
            pop_s = tok_valid & tok_ready;
            rd_s  = fifo_rd;
            check("valid", tok_valid, held > 0);
            check("count", tok_count, cnt);
            check("starved", starved, enable && fifo_empty && held == 0 && !rd_prev);
            check("rd", fifo_rd, enable && !fifo_empty &&
                  (held + int'(rd_prev) - int'(held > 0 && tok_ready)) < 2);
            check("occ_next_le2", (held + int'(rd_prev) - int'(pop_s)) <= 2, 1);
            if (pop_s && eq.size() > 0) check("data", tok_data, eq[0]);
            streak = fifo_rd ? streak + 1 : 0;
            if (streak > max_streak) max_streak = streak;
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (pop_s && eq.size() > 0) void'(eq.pop_front());
            if (pop_s) begin
                held--;
                cnt = (cnt + 1) % 16;
            end
            if (rd_prev) held++;
            rd_prev = rd_s;
            if (rd_s && fq.size() > 0) begin
                fifo_dout <= fq[0];
                eq.push_back(fq.pop_front());
            end
            if (rd_s) rd_total++;
        end
        fifo_empty <= fq.size() == 0;
    end

    always @(negedge reset_n) begin
        eq.delete();
        held = 0;
        cnt = 0;
        rd_prev = 0;
        rd_s = 0;
        pop_s = 0;
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(3);
        check("rst_data", tok_data, 0);
        reset_n = 1;
        // prime then burst
        tok_ready = 1;
        for (int i = 1; i <= 5; i++) push(B'(i));
        max_streak = 0;
        r0 = rd_total;
        enable = 1;
        cyc(12);
        check("burst_rd", rd_total - r0, 5);
        check("burst_streak", max_streak, 5);
        check("burst_count", tok_count, 5);
        check("burst_starved", starved, 1);
        // backpressure
        tok_ready = 0;
        r0 = rd_total;
        push(16'h000A); push(16'h000B); push(16'h000C);
        cyc(6);
        check("bp_reads", rd_total - r0, 2);
        check("bp_occ", held, 2);
        check("bp_head", tok_data, 16'h000A);
        cyc(2);
        check("bp_head_stable", tok_data, 16'h000A);
        c0 = cnt;
        tok_ready = 1;
        cyc(6);
        check("bp_drained", tok_count, (c0 + 3) % 16);
        // empty-channel blocking
        tok_ready = 0;
        cyc(1);
        #1;
        check("blk_rd", fifo_rd, 0);
        check("blk_starved", starved, 1);
        push(16'h1234);
        n = 0;
        while (!tok_valid && n < 6) begin
            cyc(1);
            #1;
            n++;
        end
        check("blk_valid", tok_valid, 1);
        check("blk_latency", n <= 3, 1);
        check("blk_unstarved", starved, 0);
        check("blk_data", tok_data, 16'h1234);
        cyc(1);
        tok_ready = 1;
        cyc(3);
        // enable drop one cycle after a read; word 0 is a legal token
        enable = 0;
        push(16'h0000); push(16'h5555); push(16'hAAAA);
        cyc(2);
        r0 = rd_total;
        c0 = cnt;
        enable = 1;
        cyc(1);
        enable = 0;
        cyc(6);
        check("en_reads", rd_total - r0, 1);
        check("en_fifo_left", fq.size(), 2);
        check("en_delivered", tok_count, (c0 + 1) % 16);
        enable = 1;
        cyc(6);
        // async reset between edges with two words buffered
        tok_ready = 0;
        push(16'h0101); push(16'h0202); push(16'h0303);
        cyc(6);
        check("ar_occ", held, 2);
        check("ar_valid_pre", tok_valid, 1);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        check("ar_valid", tok_valid, 0);
        check("ar_count", tok_count, 0);
        check("ar_rd", fifo_rd, 0);
        check("ar_data", tok_data, 0);
        cyc(2);
        reset_n = 1;
        tok_ready = 1;
        cyc(8);
        // counter wrap at CW=4
        enable = 0;
        reset_n = 0;
        cyc(2);
        reset_n = 1;
        for (int i = 0; i < 17; i++) push(B'($urandom));
        enable = 1;
        cyc(30);
        check("wrap_count", tok_count, 1);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            enable = $urandom_range(0, 7) != 0;
            tok_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 2) == 0) push($urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom));
            cyc(1);
        end
        enable = 1;
        tok_ready = 1;
        cyc(20);
        check("rand_fifo_drained", fq.size(), 0);
        check("rand_buf_drained", tok_valid, 0);
        check("rand_sb_empty", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/kpn_channel_reader.md
# kpn_channel_reader

Consumer-side endpoint for a KPN channel FIFO. It implements Kahn blocking-read semantics: it pops words from the channel FIFO and hands them to the downstream process over a valid/ready token interface. The FIFO's one-cycle registered read latency is absorbed by a 2-entry skid buffer, so a word is never lost or duplicated and throughput stays at one token per cycle. The block sits between every channel FIFO and the process node that consumes it.

## Interface
- B, 16, token width in bits; must match the channel FIFO word width.
- CW, 16, width of the token counter.

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new FIFO reads are issued; in-flight and buffered words still drain.
- fifo_empty  in  1  channel FIFO empty flag, registered in the FIFO.
- fifo_rd  out  1  read strobe to the FIFO; combinational.
- fifo_dout  in  B  FIFO read data, valid on the cycle after fifo_rd was high.
- tok_valid  out  1  the head token is available.
- tok_data  out  B  head token; meaningful only while tok_valid=1.
- tok_ready  in  1  the downstream process accepts the token.
- tok_count  out  CW  number of tokens accepted downstream since reset; wraps modulo 2^CW.
- starved  out  1  the process is blocked on an empty channel.

## Operation
- Internal state:
  - occ: occupancy of the 2-entry in-order skid buffer, range 0..2.
  - inflight: 1 when fifo_rd was high in the previous cycle.
- The buffer holds 0, 1 or 2 words, giving occupancy states S0, S1 and S2.
- pop = tok_valid & tok_ready.
- Issue rule:
  - fifo_rd = reset_n & enable & ~fifo_empty & ((occ + inflight − pop) < 2).
  - fifo_rd is never asserted while fifo_empty=1.
- Capture rule:
  - When inflight=1, fifo_dout is written into the buffer at that clock edge.
  - If the buffer is empty, or becomes empty through a same-cycle pop, the captured word becomes the new head.
- Buffer next-state:
  - occ_next = occ + inflight − pop.
  - The issue rule guarantees occ_next ≤ 2.
  - occ_next > 2 is a design error and must be flagged by a bench assertion.
- Token outputs:
  - tok_valid = (occ > 0).
  - tok_data = buffer head.
  - Tokens leave in strict FIFO order.
- tok_count increments by 1 on every pop and wraps from 2^CW−1 to 0.
- starved = enable & fifo_empty & (occ == 0) & ~inflight.
- Simultaneous capture and pop in S1: the head is replaced by the captured word and occupancy stays at 1.
- Simultaneous capture and pop in S2 cannot occur, because the issue rule prevents it.
- enable falling mid-operation:
  - No new reads are issued.
  - An outstanding inflight word is still captured.
  - The buffer drains normally.
- Word value 0 is a legal token and is forwarded like any other word.

## Timing
- Reset (asynchronous, reset_n=0) clears:
  - occ=0, inflight=0, tok_valid=0, tok_data=0, tok_count=0.
  - fifo_rd=0 (forced combinationally); starved=0.
- Latency: fifo_rd high in cycle N → fifo_dout captured at the end of N+1 → tok_valid=1 in N+2.
- Throughput: with tok_ready held at 1 and the FIFO non-empty, fifo_rd stays high every cycle and one token pops per cycle once the pipeline is primed.
- If reset_n is asserted mid-transfer, the inflight word is discarded and the buffer is cleared. The FIFO-side pointer advance is not undone; this is accepted behaviour for a system-wide reset.
- tok_data and tok_valid are registered outputs. fifo_rd depends combinationally on tok_ready.

## Test plan
- Prime then burst:
  - Stimulus: reset, FIFO preloaded with 0x0001..0x0005, tok_ready=1, enable=1.
  - Required: fifo_rd high for 5 consecutive cycles; tokens 0x0001..0x0005 on 5 consecutive cycles starting 2 cycles after the first rd; tok_count=5; starved=1 afterwards.
- Backpressure:
  - Stimulus: FIFO holds 0x0A, 0x0B, 0x0C; tok_ready=0.
  - Required: exactly 2 reads issued; occ=2; tok_data=0x0A held stable.
  - Then raise tok_ready: order 0x0A, 0x0B, 0x0C with no loss or duplicate.
- Empty-channel blocking:
  - Stimulus: FIFO empty, enable=1.
  - Required: fifo_rd=0 and starved=1.
  - Then write 0x1234: tok_valid rises within 3 cycles and starved falls.
- enable drop mid-stream:
  - Stimulus: deassert enable one cycle after an rd.
  - Required: the inflight word is delivered; no further fifo_rd; FIFO contents are untouched.
- Async reset mid-operation:
  - Stimulus: assert reset_n=0 between clock edges with occ=2.
  - Required: tok_valid=0, tok_count=0 and fifo_rd=0 immediately, with no clock edge needed.
- Counter wrap:
  - Stimulus: CW=4; 17 tokens popped.
  - Required: tok_count=1.
